tfm_cmul_pipe: RTL and testbench
================================

Name: tfm_cmul_pipe

Overview:
- Next-generation twiddle-factor multiplier for the FFT/IFFT datapath.
- Multiplies LANES independent complex samples by per-lane complex twiddles (signed Q1.(ROM_WIDTH-1)).
- Direction (FFT/IFFT) is selectable per sample at runtime; IFFT conjugates the twiddle.
- Adds round-half-up, saturation with sticky overflow flags, a frame-marker sideband, and valid/ready backpressure.
- Sits between the twiddle ROM and the butterfly stage.

Parameters:
- DATA_WIDTH, 16: signed width of each sample component, re and im.
- ROM_WIDTH, 18: signed width of each twiddle component, Q1.(ROM_WIDTH-1).
- LANES, 2: number of parallel complex lanes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_inv  in  1  0 = FFT (W as given), 1 = IFFT (conj W); sampled with the beat.
- in_last  in  1  frame marker, passed through aligned with data.
- in_re  in  LANES*DATA_WIDTH  sample real parts; lane k at [k*DATA_WIDTH +: DATA_WIDTH].
- in_im  in  LANES*DATA_WIDTH  sample imaginary parts.
- tw_re  in  LANES*ROM_WIDTH  twiddle real parts.
- tw_im  in  LANES*ROM_WIDTH  twiddle imaginary parts.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  delayed in_last.
- out_re  out  LANES*DATA_WIDTH  product real parts.
- out_im  out  LANES*DATA_WIDTH  product imaginary parts.
- ovf  out  LANES  sticky per-lane saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst=0, async): all stage valids, out_valid, out_last, out_re, out_im and ovf go to 0. Pipeline contents are discarded, including beats in flight when reset hits mid-stream.
- Handshake:
  - A beat transfers when valid&&ready on either side.
  - adv = ~out_valid | out_ready; in_ready = adv (combinational).
  - All stages shift only when adv=1; with adv=0 every stage holds.
  - out_* are stable while out_valid=1 and out_ready=0.
- Latency: 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle. Bubbles propagate as invalid stages and are not collapsed.
- Stage 1 (twiddle and products):
  - Extend W components to ROM_WIDTH+1 bits.
  - If inv=1, wi' = -wi at ROM_WIDTH+1 bits, so -(-1.0) = +1.0 exactly; otherwise wi' = wi.
  - Register the four signed products dr*wr, di*wi', dr*wi', di*wr, each DATA_WIDTH+ROM_WIDTH+1 bits.
  - Register inv and last alongside.
- Stage 2 (combine and round):
  - re = dr*wr - di*wi'; im = dr*wi' + di*wr, each DATA_WIDTH+ROM_WIDTH+2 bits.
  - Add 2^(ROM_WIDTH-2), then arithmetic shift right by ROM_WIDTH-1. This is round-half-toward-+inf.
  - Register the results.
- Stage 3 (saturate): clamp each component to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- ovf[k]:
  - Set to 1 when lane k clamps either component on a valid beat advancing into the output register.
  - ovf_clr=1 clears all bits. If a set and a clear occur in the same cycle, the set wins.
- Lanes are fully independent. in_inv and in_last are shared by all lanes.
- Output data of invalid beats is don't-care, but out_valid must never assert spuriously.

Test Plan:
1. Identity (all numeric tests use defaults, both lanes): in=(1000,0), W=(131071,0), inv=0 -> out=(1000,0) after 3 cycles; ovf=0.
2. Multiply by -j: in=(1000,2000), W=(0,-131072).
   - inv=0 -> (2000,-1000).
   - Same beat with inv=1 -> (-2000,1000); checks exact conjugation of -1.0.
3. Rounding:
   - in=(1,0), W=(65536,0) -> (1,0).
   - in=(-1,0), W=(65536,0) -> (0,0).
   - in=(3,0), W=(65536,0) -> (2,0).
4. Saturation: lane0 in=(-32768,0), W=(-131072,0) -> out=(32767,0), ovf=2'b01, lane1 unaffected.
   - ovf holds until ovf_clr pulses.
   - ovf_clr coincident with another saturating beat -> ovf stays 1.
5. Backpressure:
   - Stream 10 beats (in_re = 1..10, W = 1.0, in_last on beat 10).
   - Randomly toggle out_ready and in_valid.
   - Expected: outputs 1..10 in order, no loss or duplication, out_last only with value 10, out_* stable while stalled, in_ready = ~out_valid|out_ready.
6. Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0, outputs 0, ovf=0 immediately. After release, the first new beat emerges exactly 3 cycles after transfer with no stale beats.

Source files
------------

// File: rtl/tfm_cmul_pipe_if.sv
// tfm_cmul_pipe_if: the stream bus for the twiddle multiplier.
//   Input side : in_valid/in_ready handshake, in_inv, in_last, and the
//                sample (in_re/in_im) and twiddle (tw_re/tw_im) lane buses.
//   Output side: out_valid/out_ready handshake, out_last, out_re/out_im.
// Lane k of every bus sits at [k*W +: W].
// The master modport is the producer/consumer around the block; the slave
// modport is the multiplier itself.
interface tfm_cmul_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ROM_WIDTH  = 18,
    parameter int LANES      = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_inv;
    logic                        in_last;
    logic [LANES*DATA_WIDTH-1:0] in_re;
    logic [LANES*DATA_WIDTH-1:0] in_im;
    logic [LANES*ROM_WIDTH-1:0]  tw_re;
    logic [LANES*ROM_WIDTH-1:0]  tw_im;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic [LANES*DATA_WIDTH-1:0] out_re;
    logic [LANES*DATA_WIDTH-1:0] out_im;

    modport master (
        output in_valid, in_inv, in_last, in_re, in_im, tw_re, tw_im, out_ready,
        input  in_ready, out_valid, out_last, out_re, out_im
    );

    modport slave (
        input  in_valid, in_inv, in_last, in_re, in_im, tw_re, tw_im, out_ready,
        output in_ready, out_valid, out_last, out_re, out_im
    );
endinterface

// File: rtl/tfm_cmul_pipe.sv
// tfm_cmul_pipe: LANES-wide complex multiply of samples by twiddles for the
// FFT/IFFT datapath. Three register stages: products, combine+round,
// saturate. in_inv=1 conjugates the twiddle. Rounding is half toward +inf,
// saturation is per component with a sticky per-lane ovf flag.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   bus      tfm_cmul_pipe_if.slave (valid/ready in and out, data, twiddles)
//   ovf_clr  synchronous clear of ovf (a simultaneous set wins)
//   ovf      sticky per-lane saturation flags

// One lane of the multiplier. All stages move together on adv.
//   dr/di   sample, wr/wi twiddle, inv conjugate select
//   re/im   saturated output register
//   sat     the value now in stage 2 will clamp when it moves to the output
module tfm_cmul_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int ROM_WIDTH  = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         adv,
    input  logic                         inv,
    input  logic signed [DATA_WIDTH-1:0] dr,
    input  logic signed [DATA_WIDTH-1:0] di,
    input  logic signed [ROM_WIDTH-1:0]  wr,
    input  logic signed [ROM_WIDTH-1:0]  wi,
    output logic signed [DATA_WIDTH-1:0] re,
    output logic signed [DATA_WIDTH-1:0] im,
    output logic                         sat
);
    localparam int WW  = ROM_WIDTH + 1;
    localparam int PW  = DATA_WIDTH + ROM_WIDTH + 1;
    localparam int SW  = PW + 1;
    localparam int RSW = SW - (ROM_WIDTH - 1);

    localparam logic signed [SW-1:0] RND =
        {{(SW-ROM_WIDTH+1){1'b0}}, 1'b1, {(ROM_WIDTH-2){1'b0}}};
    localparam logic signed [RSW-1:0] MAXV = RSW'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [RSW-1:0] MINV = RSW'(-(1 << (DATA_WIDTH-1)));
    localparam logic [DATA_WIDTH-1:0] MAXO = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MINO = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // One extra bit so that negating -1.0 gives exactly +1.0.
    logic signed [WW-1:0] wr_x, wi_x, wi_c;
    assign wr_x = {wr[ROM_WIDTH-1], wr};
    assign wi_x = {wi[ROM_WIDTH-1], wi};
    assign wi_c = inv ? -wi_x : wi_x;

    logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0]  s_re, s_im;
    logic signed [RSW-1:0] r_re, r_im;
    logic                  sat_re, sat_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (adv) begin
            p_rr <= PW'(dr) * PW'(wr_x);
            p_ii <= PW'(di) * PW'(wi_c);
            p_ri <= PW'(dr) * PW'(wi_c);
            p_ir <= PW'(di) * PW'(wr_x);
        end
    end

    // Adding half an LSB then shifting arithmetically rounds half toward +inf.
    assign s_re = SW'(p_rr) - SW'(p_ii) + RND;
    assign s_im = SW'(p_ri) + SW'(p_ir) + RND;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_re <= '0;
            r_im <= '0;
        end else if (adv) begin
            r_re <= RSW'(s_re >>> (ROM_WIDTH-1));
            r_im <= RSW'(s_im >>> (ROM_WIDTH-1));
        end
    end

    assign sat_re = (r_re > MAXV) || (r_re < MINV);
    assign sat_im = (r_im > MAXV) || (r_im < MINV);
    assign sat    = sat_re | sat_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re <= '0;
            im <= '0;
        end else if (adv) begin
            re <= sat_re ? (r_re[RSW-1] ? MINO : MAXO) : r_re[DATA_WIDTH-1:0];
            im <= sat_im ? (r_im[RSW-1] ? MINO : MAXO) : r_im[DATA_WIDTH-1:0];
        end
    end
endmodule

module tfm_cmul_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int ROM_WIDTH  = 18,
    parameter int LANES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    tfm_cmul_pipe_if.slave   bus,
    input  logic             ovf_clr,
    output logic [LANES-1:0] ovf
);
    localparam int STAGES = 3;

    logic                             adv;
    logic [STAGES:1]                  vld_pipe;
    logic [STAGES:1]                  last_pipe;
    logic [LANES-1:0]                 sat;
    logic [LANES-1:0][DATA_WIDTH-1:0] re_l, im_l;

    // Whole pipe moves as one: free whenever the output slot is empty or taken.
    assign adv           = ~vld_pipe[STAGES] | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_last  = last_pipe[STAGES];
    assign bus.out_re    = re_l;
    assign bus.out_im    = im_l;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], bus.in_valid};
            last_pipe <= {last_pipe[STAGES-1:1], bus.in_last & bus.in_valid};
        end
    end

    // Set only for a valid beat entering the output register; set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf <= '0;
        else
            ovf <= (ovf & ~{LANES{ovf_clr}}) |
                   ({LANES{adv & vld_pipe[STAGES-1]}} & sat);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        tfm_cmul_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ROM_WIDTH (ROM_WIDTH)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .adv (adv),
            .inv (bus.in_inv),
            .dr  (bus.in_re[k*DATA_WIDTH +: DATA_WIDTH]),
            .di  (bus.in_im[k*DATA_WIDTH +: DATA_WIDTH]),
            .wr  (bus.tw_re[k*ROM_WIDTH +: ROM_WIDTH]),
            .wi  (bus.tw_im[k*ROM_WIDTH +: ROM_WIDTH]),
            .re  (re_l[k]),
            .im  (im_l[k]),
            .sat (sat[k])
        );
    end
endmodule

// File: tb/tb_tfm_cmul_pipe.sv
// tb_tfm_cmul_pipe: self-checking bench for tfm_cmul_pipe. Directed beats
// with hand-computed results, plus streamed random beats under random
// backpressure scored against an integer complex-multiply model.
`timescale 1ns/1ps
module tb_tfm_cmul_pipe;
    localparam int DW    = 16;
    localparam int RW    = 18;
    localparam int LANES = 2;
    localparam int BW    = LANES * DW;

    typedef struct {
        int dr[LANES];
        int di[LANES];
        int wr[LANES];
        int wi[LANES];
        bit inv;
        bit last;
    } beat_t;

    typedef struct {
        logic [BW-1:0]    re;
        logic [BW-1:0]    im;
        bit               last;
        logic [LANES-1:0] sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             ovf_clr;
    logic [LANES-1:0] ovf;
    int total = 0;
    int bad   = 0;

    tfm_cmul_pipe_if #(.DATA_WIDTH(DW), .ROM_WIDTH(RW), .LANES(LANES)) bus();

    tfm_cmul_pipe #(.DATA_WIDTH(DW), .ROM_WIDTH(RW), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ovf_clr(ovf_clr), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input longint v, output bit s);
        longint lim;
        lim = longint'(1) << (DW-1);
        s = 1'b1;
        if (v > lim - 1) return int'(lim - 1);
        if (v < -lim)    return int'(-lim);
        s = 1'b0;
        return int'(v);
    endfunction

    function automatic exp_t model(input beat_t b);
        exp_t   e;
        longint w2, pr, pi, half, one;
        bit     s1, s2;
        int     vr, vi;
        half = longint'(1) << (RW-2);
        one  = longint'(1) << (RW-1);
        e.re = '0; e.im = '0; e.sat = '0; e.last = b.last;
        for (int k = 0; k < LANES; k++) begin
            w2 = b.inv ? -longint'(b.wi[k]) : longint'(b.wi[k]);
            pr = longint'(b.dr[k]) * longint'(b.wr[k]) - longint'(b.di[k]) * w2;
            pi = longint'(b.dr[k]) * w2 + longint'(b.di[k]) * longint'(b.wr[k]);
            vr = clamp(floor_div(pr + half, one), s1);
            vi = clamp(floor_div(pi + half, one), s2);
            e.re[k*DW +: DW] = DW'(vr);
            e.im[k*DW +: DW] = DW'(vi);
            e.sat[k] = s1 | s2;
        end
        return e;
    endfunction

    function automatic int srand(input int w);
        logic [31:0] r;
        int v;
        r = $urandom;
        v = int'(r << (32 - w));
        return v >>> (32 - w);
    endfunction

    function automatic beat_t mk(input int dr0, di0, wr0, wi0, dr1, di1, wr1, wi1,
                                 input bit inv, input bit last);
        beat_t b;
        b.dr[0] = dr0; b.di[0] = di0; b.wr[0] = wr0; b.wi[0] = wi0;
        b.dr[1] = dr1; b.di[1] = di1; b.wr[1] = wr1; b.wi[1] = wi1;
        b.inv = inv; b.last = last;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        bus.in_inv  = b.inv;
        bus.in_last = b.last;
        for (int k = 0; k < LANES; k++) begin
            bus.in_re[k*DW +: DW] = DW'(b.dr[k]);
            bus.in_im[k*DW +: DW] = DW'(b.di[k]);
            bus.tw_re[k*RW +: RW] = RW'(b.wr[k]);
            bus.tw_im[k*RW +: RW] = RW'(b.wi[k]);
        end
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
    endtask

    // Single beat with an unstalled output; checks 3-cycle latency and data.
    // clr raises ovf_clr on the edge the beat enters the output register.
    task automatic do_beat(input beat_t b, input int er0, ei0, er1, ei1,
                           input bit clr, input string nm);
        logic [BW-1:0] xr, xi;
        xr = {DW'(er1), DW'(er0)};
        xi = {DW'(ei1), DW'(ei0)};
        bus.out_ready = 1'b1;
        drive(b);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s early_valid cyc%0d: got %b want 0", nm, i, bus.out_valid);
            end
            if (i == 2) ovf_clr = clr;
            @(posedge clk); #1;
        end
        ovf_clr = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: out_valid got %b want 1", nm, bus.out_valid);
        end
        total++;
        if (bus.out_re !== xr || bus.out_im !== xi) begin
            bad++;
            $display("FAIL %s data: re %h im %h want re %h im %h", nm, bus.out_re, bus.out_im, xr, xi);
        end
        total++;
        if (bus.out_last !== b.last) begin
            bad++;
            $display("FAIL %s last: got %b want %b", nm, bus.out_last, b.last);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s duplicate: out_valid got %b want 0", nm, bus.out_valid);
        end
    endtask

    // Streams n beats with random in_valid/out_ready, scoreboarded by model().
    task automatic run_stream(input int n, input bit rnd, input int rdy_pct,
                              input int vld_pct, input string nm,
                              output logic [LANES-1:0] ovf_exp, output int cycles);
        beat_t         bt[$];
        exp_t          q[$];
        beat_t         b;
        exp_t          e;
        int            sent, got, cyc;
        bit            stall;
        logic [BW-1:0] hr, hi;
        logic          hl;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < LANES; k++) begin
                if (rnd) begin
                    b.dr[k] = srand(DW); b.di[k] = srand(DW);
                    b.wr[k] = srand(RW); b.wi[k] = srand(RW);
                end else begin
                    b.dr[k] = (k == 0) ? i + 1 : -(i + 1);
                    b.di[k] = 0; b.wr[k] = 131071; b.wi[k] = 0;
                end
            end
            b.inv  = rnd ? 1'($urandom_range(1)) : 1'b0;
            b.last = rnd ? ($urandom_range(3) == 0) : (i == n - 1);
            bt.push_back(b);
        end
        sent = 0; got = 0; cyc = 0; stall = 1'b0;
        hr = '0; hi = '0; hl = 1'b0; ovf_exp = '0;
        while (got < n && cyc < 4000) begin
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            if (sent < n && $urandom_range(99) < vld_pct) begin
                drive(bt[sent]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            total++;
            if (bus.in_ready !== (~bus.out_valid | bus.out_ready)) begin
                bad++;
                $display("FAIL %s in_ready: got %b want %b", nm, bus.in_ready, ~bus.out_valid | bus.out_ready);
            end
            if (stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_re !== hr || bus.out_im !== hi || bus.out_last !== hl) begin
                    bad++;
                    $display("FAIL %s stall_hold: v %b re %h im %h want v 1 re %h im %h", nm, bus.out_valid, bus.out_re, bus.out_im, hr, hi);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL %s spurious beat: re %h want none", nm, bus.out_re);
                end else begin
                    e = q.pop_front();
                    if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_last !== e.last) begin
                        bad++;
                        $display("FAIL %s beat%0d: re %h im %h last %b want re %h im %h last %b", nm, got, bus.out_re, bus.out_im, bus.out_last, e.re, e.im, e.last);
                    end
                    got++;
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                e = model(bt[sent]);
                ovf_exp = ovf_exp | e.sat;
                q.push_back(e);
                sent++;
            end
            stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            hr = bus.out_re; hi = bus.out_im; hl = bus.out_last;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL %s timeout: got %0d beats want %0d", nm, got, n);
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s extra beat after drain: out_valid %b want 0", nm, bus.out_valid);
        end
        cycles = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        total++;
        if (bus.out_re !== '0 || bus.out_im !== '0) begin bad++; $display("FAIL reset data: re %h im %h want 0", bus.out_re, bus.out_im); end
        total++;
        if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset out_last: got %b want 0", bus.out_last); end
        total++;
        if (ovf !== '0) begin bad++; $display("FAIL reset ovf: got %b want 0", ovf); end
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        do_beat(mk(1000, 0, 131071, 0, 1000, 0, 131071, 0, 1'b0, 1'b0), 1000, 0, 1000, 0, 1'b0, "identity");
        total++;
        if (ovf !== 2'b00) begin bad++; $display("FAIL identity ovf: got %b want 00", ovf); end
    endtask

    task automatic test_neg_j();
        do_beat(mk(1000, 2000, 0, -131072, 1000, 2000, 0, -131072, 1'b0, 1'b1), 2000, -1000, 2000, -1000, 1'b0, "neg_j_fft");
        do_beat(mk(1000, 2000, 0, -131072, 1000, 2000, 0, -131072, 1'b1, 1'b0), -2000, 1000, -2000, 1000, 1'b0, "neg_j_ifft");
    endtask

    task automatic test_rounding();
        do_beat(mk(1, 0, 65536, 0, 1, 0, 65536, 0, 1'b0, 1'b0), 1, 0, 1, 0, 1'b0, "round_p1");
        do_beat(mk(-1, 0, 65536, 0, -1, 0, 65536, 0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0, "round_m1");
        do_beat(mk(3, 0, 65536, 0, -3, 0, 65536, 0, 1'b0, 1'b0), 2, 0, -1, 0, 1'b0, "round_3");
    endtask

    task automatic test_saturation();
        beat_t s;
        s = mk(-32768, 0, -131072, 0, 1000, 0, 131071, 0, 1'b0, 1'b0);
        do_beat(s, 32767, 0, 1000, 0, 1'b0, "sat_lane0");
        total++;
        if (ovf !== 2'b01) begin bad++; $display("FAIL sat ovf_set: got %b want 01", ovf); end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ovf !== 2'b01) begin bad++; $display("FAIL sat ovf_hold: got %b want 01", ovf); end
        clear_ovf();
        total++;
        if (ovf !== 2'b00) begin bad++; $display("FAIL sat ovf_clr: got %b want 00", ovf); end
        do_beat(s, 32767, 0, 1000, 0, 1'b1, "sat_clr_same_cycle");
        total++;
        if (ovf !== 2'b01) begin bad++; $display("FAIL sat set_beats_clr: got %b want 01", ovf); end
        // lane 1 clamps on its imaginary part only
        do_beat(mk(5, 0, 131071, 0, 0, -32768, -131072, 0, 1'b0, 1'b0), 5, 0, 0, 32767, 1'b0, "sat_lane1_im");
        total++;
        if (ovf !== 2'b11) begin bad++; $display("FAIL sat lane1 ovf: got %b want 11", ovf); end
        clear_ovf();
    endtask

    task automatic test_backpressure();
        logic [LANES-1:0] oe;
        int c;
        run_stream(10, 1'b0, 50, 70, "backpressure", oe, c);
        total++;
        if (ovf !== oe) begin bad++; $display("FAIL backpressure ovf: got %b want %b", ovf, oe); end
    endtask

    task automatic test_back_to_back();
        logic [LANES-1:0] oe;
        int c;
        clear_ovf();
        run_stream(30, 1'b1, 100, 100, "back_to_back", oe, c);
        total++;
        if (c != 33) begin bad++; $display("FAIL back_to_back throughput: cycles %0d want 33", c); end
        total++;
        if (ovf !== oe) begin bad++; $display("FAIL back_to_back ovf: got %b want %b", ovf, oe); end
    endtask

    task automatic test_random();
        logic [LANES-1:0] oe;
        int c;
        clear_ovf();
        run_stream(200, 1'b1, 60, 80, "random", oe, c);
        total++;
        if (ovf !== oe) begin bad++; $display("FAIL random ovf: got %b want %b", ovf, oe); end
        clear_ovf();
    endtask

    task automatic test_reset_midstream();
        beat_t s, a;
        bit    seen;
        s = mk(-32768, 0, -131072, 0, 1000, 0, 131071, 0, 1'b0, 1'b0);
        a = mk(700, 0, 131071, 0, 700, 0, 131071, 0, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        drive(s); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || ovf !== 2'b01) begin
            bad++;
            $display("FAIL midrst pre: out_valid %b ovf %b want 1 01", bus.out_valid, ovf);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin bad++; $display("FAIL midrst valid: v %b last %b want 0 0", bus.out_valid, bus.out_last); end
        total++;
        if (bus.out_re !== '0 || bus.out_im !== '0) begin bad++; $display("FAIL midrst data: re %h im %h want 0", bus.out_re, bus.out_im); end
        total++;
        if (ovf !== '0) begin bad++; $display("FAIL midrst ovf: got %b want 0", ovf); end
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL midrst stale beat: out_valid seen 1 want 0"); end
        // multiply by +j: (-500 + 250j) * j = -250 - 500j
        do_beat(mk(-500, 250, 0, 131071, -500, 250, 0, 131071, 1'b0, 1'b1), -250, -500, -250, -500, 1'b0, "midrst_first");
    endtask

    initial begin
        rst = 1'b0;
        ovf_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_inv = 1'b0; bus.in_last = 1'b0;
        bus.in_re = '0; bus.in_im = '0; bus.tw_re = '0; bus.tw_im = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_identity();
        test_neg_j();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
